operand_join_fifo: RTL and testbench

- Upstream feeder for the RTL_unq1 datapath stage.
- Joins two independent valid/ready operand streams (A, B) into one paired transaction.
- Buffers up to DEPTH pairs and presents the head pair on in1/in2 with the handshake_valid/handshake_ready pair the downstream stage consumes.
- Also reports live occupancy and a sticky high-watermark for the bound monitor and debug.

---
 rtl/operand_join_fifo.sv | 86 ++++++++
 tb/tb_operand_join_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/operand_join_fifo.sv
// operand_join_fifo: joins two valid/ready operand streams into paired entries,
// buffers up to DEPTH pairs and presents the head pair to the downstream stage.
// Also reports live occupancy and a sticky high-watermark.
module operand_join_fifo #(
   parameter  int WIDTH = 5,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] in2,
   output logic             handshake_valid,
   input  logic             handshake_ready,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    max_count
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             enq;
   logic             deq;
   logic [CW-1:0]    count_next;

   // count carries one extra bit so full and empty stay distinct
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // readiness depends only on the partner valid and stored occupancy, never
   // on handshake_ready, so a full FIFO refuses input even while draining
   assign a_ready = b_valid && !full;
   assign b_ready = a_valid && !full;
   assign enq     = a_valid && b_valid && !full;

   assign handshake_valid = !empty;
   assign deq             = !empty && handshake_ready;
   assign in1             = empty ? '0 : mem_a[rd_ptr];
   assign in2             = empty ? '0 : mem_b[rd_ptr];

   // next occupancy from the enqueue/dequeue pair
   always_comb begin
      count_next = count;
      case ({enq, deq})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // pointers, occupancy and high-watermark; reset discards all entries
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         max_count <= '0;
      end else begin
         count <= count_next;
         if (count_next > max_count) max_count <= count_next;
         if (enq) wr_ptr <= wr_ptr + AW'(1);
         if (deq) rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // pair storage; contents are don't-care until written
   always_ff @(posedge CLK) begin
      if (enq) begin
         mem_a[wr_ptr] <= a_data;
         mem_b[wr_ptr] <= b_data;
      end
   end

endmodule

// File: tb/tb_operand_join_fifo.sv
// Bench for operand_join_fifo: directed steps plus randomized traffic, checked
// against a queue model of the pair FIFO.
module tb_operand_join_fifo;

   localparam int W  = 5;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic [W-1:0]  a_data = '0;
   logic          a_valid = 1'b0;
   logic          a_ready;
   logic [W-1:0]  b_data = '0;
   logic          b_valid = 1'b0;
   logic          b_ready;
   logic [W-1:0]  in1;
   logic [W-1:0]  in2;
   logic          handshake_valid;
   logic          handshake_ready = 1'b0;
   logic [CW-1:0] count;
   logic [CW-1:0] max_count;

   int total = 0;
   int bad   = 0;

   logic [2*W-1:0] q[$];
   int             mmax = 0;

   operand_join_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK(CLK), .RESET(RESET),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .in1(in1), .in2(in2),
      .handshake_valid(handshake_valid), .handshake_ready(handshake_ready),
      .count(count), .max_count(max_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive, check at negedge against the model, advance model
   task automatic cyc(input logic av, input logic [W-1:0] ad, input logic bv,
                      input logic [W-1:0] bd, input logic hr, input logic rst);
      int   n;
      logic full_m, enq_m, deq_m;
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
      handshake_ready = hr; RESET = rst;
      @(negedge CLK);
      n      = q.size();
      full_m = (n == D);
      chk("hs_valid",  32'(handshake_valid), 32'(n != 0));
      chk("in1",       32'(in1), (n != 0) ? 32'(q[0][2*W-1:W]) : 32'd0);
      chk("in2",       32'(in2), (n != 0) ? 32'(q[0][W-1:0])   : 32'd0);
      chk("a_ready",   32'(a_ready), 32'(bv && !full_m));
      chk("b_ready",   32'(b_ready), 32'(av && !full_m));
      chk("count",     32'(count), 32'(n));
      chk("max_count", 32'(max_count), 32'(mmax));
      enq_m = av && bv && !full_m;
      deq_m = (n != 0) && hr;
      @(posedge CLK);
      if (rst) begin
         q.delete();
         mmax = 0;
      end else begin
         if (deq_m) void'(q.pop_front());
         if (enq_m) q.push_back({ad, bd});
         if (q.size() > mmax) mmax = q.size();
      end
      #1;
   endtask

   initial begin
      logic [W-1:0] da, db;
      logic         av, bv, hr, rst;
      int           n0;

      // power-on reset without checks (state is unknown before it)
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;

      // idle after reset
      repeat (5) cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

      // A waits for B; join only when both valid
      repeat (3) cyc(1'b1, 5'h03, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 5'h03, 1'b1, 5'h1C, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      chk("dir_join_count", 32'(count), 32'd1);
      chk("dir_join_in1",   32'(in1),   32'h03);
      chk("dir_join_in2",   32'(in2),   32'h1C);

      // drain, then fill to full with downstream stalled
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         cyc(1'b1, W'(2*i+1), 1'b1, W'(2*i+2), 1'b0, 1'b0);
      cyc(1'b1, 5'd9, 1'b1, 5'd10, 1'b0, 1'b0);
      chk("dir_full_count", 32'(count), 32'd4);
      chk("dir_full_max",   32'(max_count), 32'd4);
      chk("dir_full_ready", 32'(a_ready), 32'd0);
      repeat (4) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      // wrap: pointers have gone round once
      cyc(1'b1, 5'd9, 1'b1, 5'd10, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      chk("dir_wrap_in1", 32'(in1), 32'd9);
      chk("dir_wrap_in2", 32'(in2), 32'd10);

      // refill to full, then both valids and ready high together
      for (int i = 0; i < 3; i++)
         cyc(1'b1, W'(i+11), 1'b1, W'(i+21), 1'b0, 1'b0);
      da = 5'd1; db = 5'd2;
      for (int i = 0; i < 10; i++) begin
         n0 = q.size();
         cyc(1'b1, da, 1'b1, db, 1'b1, 1'b0);
         if (n0 < D) begin da = da + W'(3); db = db + W'(5); end
      end

      // streaming at one pair per cycle from count=1
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, 5'd4, 1'b1, 5'd7, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
         cyc(1'b1, W'(i+5), 1'b1, W'(i+17), 1'b1, 1'b0);
      chk("dir_stream_max", 32'(max_count), 32'd1);

      // reset with three entries held
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b0);
      cyc(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
      chk("dir_pre_rst_count", 32'(count), 32'd3);
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      chk("dir_rst_count", 32'(count), 32'd0);
      chk("dir_rst_max",   32'(max_count), 32'd0);
      cyc(1'b1, 5'h11, 1'b1, 5'h0A, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      chk("dir_post_rst_count", 32'(count), 32'd0);

      // randomized traffic; valid data held until the pair is taken
      av = 1'b0; bv = 1'b0; da = '0; db = '0;
      for (int i = 0; i < 400; i++) begin
         if (!av && ($urandom % 2 == 0)) begin av = 1'b1; da = W'($urandom); end
         if (!bv && ($urandom % 2 == 0)) begin bv = 1'b1; db = W'($urandom); end
         hr  = ($urandom % 3 != 0);
         rst = ($urandom % 89 == 0);
         n0  = q.size();
         cyc(av, da, bv, db, hr, rst);
         if (av && bv && n0 < D) begin av = 1'b0; bv = 1'b0; end
      end
      repeat (6) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
